// File: rtl/mem_bus_ctrl.sv
// MEM stage: drives load/store accesses over a req/ack bus, aligns load data
// (big-endian lanes), stalls the pipeline while an access is outstanding, and
// passes non-memory results and HI/LO/CP0 write info through to MEM/WB.
module mem_bus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              whilo_i,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic              cp0_we_i,
  input  logic [4:0]        cp0_waddr_i,
  input  logic [DATA_W-1:0] cp0_wdata_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o,
  output logic              cp0_we_o,
  output logic [4:0]        cp0_waddr_o,
  output logic [DATA_W-1:0] cp0_wdata_o,
  output logic              stallreq_o
);

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q;
  logic              bus_req_q, bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_sel_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] rbuf_q;

  logic              is_load, is_store, is_mem, sext;
  logic [1:0]        sz;
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] st_data, ld_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Only the MEM/WB hold bit matters here.
  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  // Decode opcode into access kind, size and sign handling.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz       = SZ_W;
    sext     = 1'b0;
    case (aluop_i)
      OP_LB:   begin is_load = 1'b1;  sz = SZ_B; sext = 1'b1; end
      OP_LBU:  begin is_load = 1'b1;  sz = SZ_B; end
      OP_LH:   begin is_load = 1'b1;  sz = SZ_H; sext = 1'b1; end
      OP_LHU:  begin is_load = 1'b1;  sz = SZ_H; end
      OP_LW:   begin is_load = 1'b1;  sz = SZ_W; end
      OP_SB:   begin is_store = 1'b1; sz = SZ_B; end
      OP_SH:   begin is_store = 1'b1; sz = SZ_H; end
      OP_SW:   begin is_store = 1'b1; sz = SZ_W; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

  // Big-endian lane selects and replicated store data; misaligned low bits ignored.
  always_comb begin
    lane_sel = 4'b1111;
    st_data  = reg2_i;
    case (sz)
      SZ_B: begin
        case (mem_addr_i[1:0])
          2'b00:   lane_sel = 4'b1000;
          2'b01:   lane_sel = 4'b0100;
          2'b10:   lane_sel = 4'b0010;
          default: lane_sel = 4'b0001;
        endcase
        st_data = {4{reg2_i[7:0]}};
      end
      SZ_H: begin
        lane_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        st_data  = {2{reg2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Extract and extend the addressed byte/half from the read buffer.
  always_comb begin
    byte_v = 8'h00;
    case (mem_addr_i[1:0])
      2'b00:   byte_v = rbuf_q[31:24];
      2'b01:   byte_v = rbuf_q[23:16];
      2'b10:   byte_v = rbuf_q[15:8];
      default: byte_v = rbuf_q[7:0];
    endcase
    half_v  = mem_addr_i[1] ? rbuf_q[15:0] : rbuf_q[31:16];
    ld_data = rbuf_q;
    case (sz)
      SZ_B:    ld_data = {{24{sext & byte_v[7]}}, byte_v};
      SZ_H:    ld_data = {{16{sext & half_v[15]}}, half_v};
      default: ;
    endcase
  end

  // Access FSM: launch in IDLE, wait for ack in BUSY, present result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= 4'b0000;
      bus_wdata_q <= '0;
      rbuf_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mem) begin
            state_q     <= S_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= is_store;
            bus_addr_q  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            bus_sel_q   <= lane_sel;
            bus_wdata_q <= st_data;
          end
        end
        S_BUSY: begin
          if (bus_ack_i) begin
            rbuf_q    <= bus_rdata_i;
            bus_req_q <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          // Instruction stays resident while MEM/WB is held.
          if (!stall_i[4]) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stallreq_o  = ((state_q == S_IDLE) && is_mem) || (state_q == S_BUSY);

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

  assign wd_o        = wd_i;
  assign wreg_o      = wreg_i & ~stallreq_o;
  assign wdata_o     = is_load ? ld_data : wdata_i;
  assign hi_o        = hi_i;
  assign lo_o        = lo_i;
  assign whilo_o     = whilo_i;
  assign cp0_we_o    = cp0_we_i;
  assign cp0_waddr_o = cp0_waddr_i;
  assign cp0_wdata_o = cp0_wdata_i;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- MEM stage of the pipeline, fed directly by the EX/MEM pipeline register and feeding MEM/WB.
- Performs load and store accesses over a req/ack data bus.
- Aligns load data and generates byte-lane selects.
- Requests a pipeline stall while a bus access is outstanding.
- Non-memory instructions and their HI/LO and CP0 write information pass straight through to MEM/WB.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, register and bus data width; only 32 is supported.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  6  pipeline stall vector; bit 4 is the MEM/WB hold.
- wd_i  in  5  destination register address.
- wreg_i  in  1  GPR write enable.
- wdata_i  in  32  ALU result.
- hi_i, lo_i  in  32 each  HI/LO write data.
- whilo_i  in  1  HI/LO write enable.
- aluop_i  in  8  ALU opcode (defines.v encoding).
- mem_addr_i  in  32  effective address.
- reg2_i  in  32  store data (rt).
- cp0_we_i  in  1  CP0 write enable.
- cp0_waddr_i  in  5  CP0 write address.
- cp0_wdata_i  in  32  CP0 write data.
- bus_rdata_i  in  32  bus read data.
- bus_ack_i  in  1  bus acknowledge; valid for one cycle.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write strobe.
- bus_addr_o  out  32  word-aligned bus address.
- bus_sel_o  out  4  byte-lane selects.
- bus_wdata_o  out  32  bus write data.
- wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  as inputs  to MEM/WB.
- cp0_we_o, cp0_waddr_o, cp0_wdata_o  out  as inputs  to MEM/WB.
- stallreq_o  out  1  stall request to the controller.

Behaviour:
- Memory ops: EXE_LB/LBU/LH/LHU/LW_OP and EXE_SB/SH/SW_OP. Every other aluop is non-memory.
- Pass-through (combinational): wd_o, hi/lo/whilo, cp0_* always equal their inputs.
  - wreg_o = wreg_i, except forced 0 while stallreq_o=1.
  - wdata_o = wdata_i for non-memory ops and stores; the aligned load value for loads.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory op: stallreq_o=0.
  - Memory op: stallreq_o=1 (combinational); next state BUSY; register bus_req_o=1 plus bus_we_o/addr/sel/wdata.
- BUSY:
  - stallreq_o=1 and bus outputs held stable.
  - On bus_ack_i: capture bus_rdata_i into the read buffer, clear bus_req_o, go to DONE.
- DONE:
  - stallreq_o=0; the load result comes from the read buffer.
  - If stall_i[4]=1, stay in DONE (the instruction is still resident); otherwise go to IDLE.
- Latency: with ack one cycle after req, the instruction completes 3 cycles after arrival (IDLE, BUSY, DONE).
- A new memory op presented in the same cycle as DONE is impossible: EX/MEM advances only after DONE. A memory op arriving back-to-back is seen in IDLE on the next cycle.
- Address and lanes (big-endian): bus_addr_o = {mem_addr_i[31:2], 2'b00}.
  - Byte ops: offset 00/01/10/11 selects lanes 1000/0100/0010/0001.
  - Half ops: offset 00 selects 1100, offset 10 selects 0011.
  - Word ops select 1111.
  - Misaligned low bits are ignored: half uses addr[1], word uses none. No exception is raised.
- Store data: SB replicates {4{reg2_i[7:0]}}; SH replicates {2{reg2_i[15:0]}}; SW sends reg2_i.
- Load extraction: select the byte/half by the lane above.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW returns the full word.
- Stores complete with wreg_o as given by EX; normally 0.
- Reset: state IDLE; bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o and the read buffer are all 0. All combinational outputs follow from this.
- Reset during BUSY aborts: req drops the next edge and any late ack is ignored in IDLE.
- bus_ack_i outside BUSY is ignored.

Test Plan:
- ADDU result 0x1234 to r5 with no memory op -> wdata_o=0x1234, wreg_o=1, stallreq_o=0, bus_req_o never asserted.
- LB at addr 0x103, ack after 2 wait cycles, rdata 0x112233F0 -> sel 0001, addr 0x100, stallreq_o high 4 cycles, DONE wdata_o=0xFFFFFFF0.
- LHU at addr 0x202, rdata 0xAAAA8001 -> sel 0011, wdata_o=0x00008001; LH at 0x200 with rdata 0x8001AAAA -> wdata_o=0xFFFF8001.
- SB at 0x301 with reg2=0x000000CD -> we=1, sel 0100, wdata=0xCDCDCDCD; SW at 0x304 -> sel 1111, wdata=reg2.
- Load reaching DONE with stall_i[4]=1 for 2 cycles -> stays in DONE with the load value stable and no new request; goes to IDLE after the stall releases.
- rst in BUSY followed by a stray ack -> bus_req_o=0 next cycle, state IDLE, ack ignored, all outputs 0 for a NOP input.
